// File: rtl/xt_bus_pkg.sv
// Shared types for the bus master port.
//   bus_mst_state_e : master port FSM states
//   bus_cmd_t       : latched command (write flag, address, data, strobes)
// The command struct is sized for the widest bus in the system. Instances
// with narrower buses zero-extend into it and slice back out.
package xt_bus_pkg;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = BUS_DATA_W / 8;

  typedef enum logic [2:0] {IDLE, REQ, XFER, BACKOFF, RSP} bus_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_STRB_W-1:0] wstrb;
  } bus_cmd_t;
endpackage

// File: rtl/xt_bus_master_port.sv
// Initiator-side port between a bus master and the round-robin arbiter.
// Takes one command over valid/ready, requests the matching arbiter channel,
// drives the shared bus while granted, and returns a one-cycle response.
// Grant loss and grant timeout back off for one cycle and retry up to
// MAX_RETRY times; a silent slave or exhausted retries returns rsp_err.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command handshake
//   rsp_valid/rdata/err           response pulse
//   read_req/write_req            arbiter requests (only one ever high)
//   read_accept/write_accept      arbiter grants
//   bus_addr/wdata/wstrb/rd_en/wr_en          shared bus drive (0 when idle)
//   bus_rdata/bus_ready           slave return
module xt_bus_master_port
  import xt_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = BUS_ADDR_W,
  parameter int DATA_WIDTH    = BUS_DATA_W,
  parameter int GRANT_TIMEOUT = 64,
  parameter int XFER_TIMEOUT  = 256,
  parameter int MAX_RETRY     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    read_req,
  output logic                    write_req,
  input  logic                    read_accept,
  input  logic                    write_accept,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb,
  output logic                    bus_rd_en,
  output logic                    bus_wr_en,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_ready
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int GW = $clog2(GRANT_TIMEOUT + 1);
  localparam int XW = $clog2(XFER_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  bus_mst_state_e        state;
  bus_cmd_t              cmd_q;
  logic [GW-1:0]         grant_cnt;
  logic [XW-1:0]         xfer_cnt;
  logic [RW-1:0]         retry_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  acc, drive, req;

  assign acc   = cmd_q.write ? write_accept : read_accept;
  // Bus drive follows the grant combinationally so a revoked grant
  // releases the shared bus in the same cycle.
  assign drive = (state == XFER) && acc;
  assign req   = (state == REQ) || (state == XFER);

  assign cmd_ready = (state == IDLE) && !rst;
  assign read_req  = req && !cmd_q.write;
  assign write_req = req &&  cmd_q.write;

  assign bus_addr  = drive ? cmd_q.addr[ADDR_WIDTH-1:0] : '0;
  assign bus_wdata = (drive && cmd_q.write) ? cmd_q.wdata[DATA_WIDTH-1:0] : '0;
  assign bus_wstrb = (drive && cmd_q.write) ? cmd_q.wstrb[SW-1:0] : '0;
  assign bus_rd_en = drive && !cmd_q.write;
  assign bus_wr_en = drive &&  cmd_q.write;

  assign rsp_valid = (state == RSP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      grant_cnt <= '0;
      xfer_cnt  <= '0;
      retry_cnt <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      // Per-phase counters restart every time their phase is entered.
      grant_cnt <= '0;
      xfer_cnt  <= '0;
      unique case (state)
        IDLE: if (cmd_valid) begin
          cmd_q.write <= cmd_write;
          cmd_q.addr  <= BUS_ADDR_W'(cmd_addr);
          cmd_q.wdata <= BUS_DATA_W'(cmd_wdata);
          cmd_q.wstrb <= BUS_STRB_W'(cmd_wstrb);
          retry_cnt   <= '0;
          rdata_q     <= '0;
          err_q       <= 1'b0;
          state       <= REQ;
        end
        REQ: begin
          if (acc)
            state <= XFER;
          else if (grant_cnt == GW'(GRANT_TIMEOUT - 1))
            state <= BACKOFF;
          else if (grant_cnt != GW'(GRANT_TIMEOUT))
            grant_cnt <= grant_cnt + GW'(1);
          else
            grant_cnt <= grant_cnt;
        end
        XFER: begin
          // bus_ready only completes while still granted; a ready seen on
          // the cycle the grant drops is treated as grant loss.
          if (acc && bus_ready) begin
            rdata_q <= cmd_q.write ? '0 : bus_rdata;
            state   <= RSP;
          end else if (!acc) begin
            state <= BACKOFF;
          end else if (xfer_cnt == XW'(XFER_TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= RSP;
          end else if (xfer_cnt != XW'(XFER_TIMEOUT)) begin
            xfer_cnt <= xfer_cnt + XW'(1);
          end else begin
            xfer_cnt <= xfer_cnt;
          end
        end
        BACKOFF: begin
          // One req-low cycle lets the arbiter drop the stale grant.
          if (retry_cnt == RW'(MAX_RETRY)) begin
            err_q <= 1'b1;
            state <= RSP;
          end else begin
            retry_cnt <= retry_cnt + RW'(1);
            state     <= REQ;
          end
        end
        RSP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
